shiftreg_sequencer: RTL and testbench
=====================================

SHIFTREG_SEQUENCER -- requirements
Module: shiftreg_sequencer

Interface
REQ-001 SHALL have parameter DIV, default 1, meaning clock cycles per serial bit (legal range 1..255).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1 each  requester 0/1 offers a byte.
REQ-005 SHALL have ports req0_data / req1_data  input  8 each  byte from requester 0/1.
REQ-006 SHALL have ports req0_ready / req1_ready  output  1 each  byte accepted this cycle.
REQ-007 SHALL have port sin  input  1  serial input, shifted into bit 0.
REQ-008 SHALL have port sout  output  1  serial output, current bit 7 of the shifter.
REQ-009 SHALL have port sout_valid  output  1  high while a data or parity bit is on sout.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port done  output  1  one-cycle pulse at frame end.
REQ-012 SHALL have port done_id  output  1  requester whose frame completed; valid with done.
REQ-013 SHALL have port rx_data  output  8  byte captured from sin; updated with done, held otherwise.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, PARITY (only with PAR_EN), DONE.
REQ-015 In IDLE, reqN_ready SHALL be asserted combinationally for the arbitration winner only; a transfer occurs on valid&ready.
REQ-016 Arbitration SHALL be round-robin: a single valid requester wins; if both are valid, the requester indicated by the priority pointer wins; the pointer SHALL flip to the other requester after every transfer.
REQ-017 On a transfer the shifter SHALL load the winner's data, bit_cnt SHALL clear, div_cnt SHALL clear, and the FSM SHALL enter SHIFT on the next edge.
REQ-018 In SHIFT, each bit SHALL be held on sout for exactly DIV cycles, MSB first; on the last cycle of a bit the shifter SHALL shift left with sin entering bit 0.
REQ-019 After the 8th bit, the FSM SHALL enter PARITY if PAR_EN is defined, else DONE.
REQ-020 PARITY SHALL drive the even parity of the transmitted byte on sout for DIV cycles, with sout_valid high, then enter DONE.
REQ-021 DONE SHALL last one cycle, assert done, present done_id and rx_data, then return to IDLE; ready SHALL stay low in DONE.
REQ-022 Frame latency, transfer edge to done-high edge: 8*DIV+1 cycles without PAR_EN, 9*DIV+1 with it.
REQ-023 Requests SHALL be ignored while busy; a valid deasserted before acceptance SHALL leave no side effect.
REQ-024 sout SHALL be 0 and sout_valid SHALL be 0 in IDLE and DONE.

Reset
REQ-025 While rst_n=0, the FSM SHALL be IDLE, the shifter, bit_cnt, div_cnt and rx_data SHALL be 0, and the pointer SHALL select requester 0.
REQ-026 Under the same condition, ready, sout, sout_valid, busy, done and done_id SHALL be 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately with no done pulse.

Configuration
REQ-028 Macro SHIFTREG_SEQ_PARITY_EN, referred to as PAR_EN: when defined, the PARITY state and its bit SHALL exist; when undefined, the PARITY state and its logic SHALL be absent and frames SHALL be 8 bits.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding, the byte width constant (8) and the bit-count width constant.
REQ-030 The loadable shifter (parallel load, shift-left with serial-in, MSB out) SHALL be a sub-module named seq_shifter; the FSM, arbiter and counters SHALL stay in the top module.

Verification
REQ-031 DIV=1, req0 valid with 0xA5 only: req0_ready pulses once; sout reads 1,0,1,0,0,1,0,1; done at cycle 9 with done_id=0.
REQ-032 Both requesters valid from reset, with req0=0x0F and req1=0xF0: frames complete in the order req0 then req1; done_id reads 0 then 1.
REQ-033 DIV=3, sin tied to the sout of an external loop with 0x3C: each bit is held 3 cycles; rx_data=0x3C at done.
REQ-034 PAR_EN defined, 0x07 sent: the 9th bit is 1; done occurs 9*DIV+1 cycles after transfer.
REQ-035 req1 asserts valid mid-frame: req1_ready stays low until IDLE and req1 is then served next.
REQ-036 rst_n pulled low at bit 4: all outputs go to 0 immediately, no done pulse occurs, and the next request starts a clean frame.

Source files
------------

// File: rtl/shiftreg_sequencer_pkg.sv
// Shared definitions for the two-requester serial shift sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Optional feature macro: SHIFTREG_SEQ_PARITY_EN adds the PARITY state.
package shiftreg_sequencer_pkg;

   localparam int BYTE_W   = 8;   // serial frame payload width
   localparam int BITCNT_W = 4;   // enough to count 0..BYTE_W

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
`ifdef SHIFTREG_SEQ_PARITY_EN
      ST_PARITY = 2'd2,
`endif
      ST_DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/seq_shifter.sv
// Loadable byte shifter: parallel load, shift left with serial-in at bit 0, MSB out.
// Latency: load/shift take effect on the next rising edge; o_msb/o_dat are registered.
// Backpressure: none; the caller decides when to load or shift (load wins).
// Ports: i_clk/i_rst_n clock and async active-low reset; i_load/i_load_dat parallel
//        load; i_shift/i_sin shift-left strobe and serial input; o_msb bit 7; o_dat contents.
module seq_shifter
   import shiftreg_sequencer_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_load,
   input  logic [BYTE_W-1:0] i_load_dat,
   input  logic              i_shift,
   input  logic              i_sin,
   output logic              o_msb,
   output logic [BYTE_W-1:0] o_dat
);

   logic [BYTE_W-1:0] r_sh;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sh <= '0;
      end else if (i_load) begin
         r_sh <= i_load_dat;
      end else if (i_shift) begin
         r_sh <= {r_sh[BYTE_W-2:0], i_sin};
      end
   end

   assign o_msb = r_sh[BYTE_W-1];
   assign o_dat = r_sh;

endmodule

// File: rtl/shiftreg_sequencer.sv
// Two-requester round-robin serialiser: sends a byte MSB first on sout while capturing sin.
// Latency: transfer edge to done-high edge is 8*DIV+1 cycles (9*DIV+1 with parity).
// Backpressure: reqN_ready only in IDLE for the arbitration winner; requests ignored while busy.
// Ports: clk, rst_n (async active-low); reqN_valid/reqN_data/reqN_ready byte offers;
//        sin serial in; sout/sout_valid serial out; busy, done, done_id, rx_data status.
// Optional feature macro: SHIFTREG_SEQ_PARITY_EN appends an even-parity bit to each frame.
module shiftreg_sequencer
   import shiftreg_sequencer_pkg::*;
#(
   parameter int DIV = 1   // clock cycles per serial bit, 1..255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0_valid,
   input  logic [7:0] req0_data,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [7:0] req1_data,
   output logic       req1_ready,
   input  logic       sin,
   output logic       sout,
   output logic       sout_valid,
   output logic       busy,
   output logic       done,
   output logic       done_id,
   output logic [7:0] rx_data
);

   localparam logic [7:0]          DIV_LAST = 8'(DIV - 1);
   localparam logic [BITCNT_W-1:0] BIT_LAST = BITCNT_W'(BYTE_W - 1);

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_ptr;        // requester favoured when both are valid
   logic                r_id;         // requester owning the frame in flight
   logic [7:0]          r_div_cnt;
   logic [BITCNT_W-1:0] r_bit_cnt;
   logic [BYTE_W-1:0]   r_rx;
   logic [BYTE_W-1:0]   w_sh;
   logic [BYTE_W-1:0]   w_load_dat;
   logic [BYTE_W-1:0]   w_rx_nxt;
   logic                w_idle;
   logic                w_gnt0;
   logic                w_gnt1;
   logic                w_xfer;
   logic                w_bit_end;
   logic                w_last_bit;
   logic                w_shift;
   logic                w_msb;
   logic                w_to_done;
`ifdef SHIFTREG_SEQ_PARITY_EN
   logic                r_par;        // even parity of the byte being sent
`endif

   // ---------------- arbitration ----------------
   assign w_idle     = (r_state == ST_IDLE);
   assign w_gnt0     = req0_valid & (~req1_valid | ~r_ptr);
   assign w_gnt1     = req1_valid & (~req0_valid |  r_ptr);
   // rst_n gating keeps ready low while reset is held even if valid is high
   assign req0_ready = rst_n & w_idle & w_gnt0;
   assign req1_ready = rst_n & w_idle & w_gnt1;
   assign w_xfer     = req0_ready | req1_ready;
   assign w_load_dat = w_gnt1 ? req1_data : req0_data;

   // ---------------- bit timing ----------------
   assign w_bit_end  = (r_div_cnt == DIV_LAST);
   assign w_last_bit = (r_bit_cnt == BIT_LAST);
   assign w_shift    = (r_state == ST_SHIFT) & w_bit_end;

   // ---------------- FSM ----------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_xfer) w_state_nxt = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (w_bit_end && w_last_bit) begin
`ifdef SHIFTREG_SEQ_PARITY_EN
               w_state_nxt = ST_PARITY;
`else
               w_state_nxt = ST_DONE;
`endif
            end
         end
`ifdef SHIFTREG_SEQ_PARITY_EN
         ST_PARITY: begin
            if (w_bit_end) w_state_nxt = ST_DONE;
         end
`endif
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign w_to_done = (w_state_nxt == ST_DONE) && (r_state != ST_DONE);

   // Without parity the last shift and the DONE entry share an edge, so the
   // captured byte must include the sin bit being shifted in on that edge.
`ifdef SHIFTREG_SEQ_PARITY_EN
   assign w_rx_nxt = w_sh;
`else
   assign w_rx_nxt = {w_sh[BYTE_W-2:0], sin};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_ptr     <= 1'b0;
         r_id      <= 1'b0;
         r_div_cnt <= '0;
         r_bit_cnt <= '0;
         r_rx      <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_xfer) begin
            r_ptr     <= ~r_ptr;
            r_id      <= w_gnt1;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
         end else begin
            if (sout_valid) begin
               r_div_cnt <= w_bit_end ? 8'd0 : r_div_cnt + 8'd1;
            end else begin
               r_div_cnt <= '0;
            end
            if (w_shift) r_bit_cnt <= r_bit_cnt + BITCNT_W'(1);
         end
         if (w_to_done) r_rx <= w_rx_nxt;
      end
   end

`ifdef SHIFTREG_SEQ_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_par <= 1'b0;
      end else if (w_xfer) begin
         r_par <= ^w_load_dat;
      end
   end
`endif

   // ---------------- datapath ----------------
   seq_shifter u_shifter (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_load     (w_xfer),
      .i_load_dat (w_load_dat),
      .i_shift    (w_shift),
      .i_sin      (sin),
      .o_msb      (w_msb),
      .o_dat      (w_sh)
   );

   // ---------------- outputs ----------------
   always_comb begin
      sout       = 1'b0;
      sout_valid = 1'b0;
      case (r_state)
         ST_SHIFT: begin
            sout       = w_msb;
            sout_valid = 1'b1;
         end
`ifdef SHIFTREG_SEQ_PARITY_EN
         ST_PARITY: begin
            sout       = r_par;
            sout_valid = 1'b1;
         end
`endif
         default: begin
            sout       = 1'b0;
            sout_valid = 1'b0;
         end
      endcase
   end

   assign busy    = ~w_idle;
   assign done    = (r_state == ST_DONE);
   assign done_id = done & r_id;
   assign rx_data = r_rx;

endmodule

// File: tb/tb_shiftreg_sequencer.sv
// Bench for shiftreg_sequencer: DIV=1 and DIV=3 instances, cycle model plus directed checks.
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_shiftreg_sequencer;

`ifdef SHIFTREG_SEQ_PARITY_EN
   localparam int NB = 9;
`else
   localparam int NB = 8;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       v0_1, v1_1, v0_3, v1_3;
   logic [7:0] d0_1, d1_1, d0_3, d1_3;
   logic       sin1, sin3;
   logic       r0_1, r1_1, so_1, sv_1, bz_1, dn_1, di_1;
   logic       r0_3, r1_3, so_3, sv_3, bz_3, dn_3, di_3;
   logic [7:0] rx_1, rx_3;
   bit         sin_tog;

   shiftreg_sequencer #(.DIV(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(v0_1), .req0_data(d0_1), .req0_ready(r0_1),
      .req1_valid(v1_1), .req1_data(d1_1), .req1_ready(r1_1),
      .sin(sin1), .sout(so_1), .sout_valid(sv_1), .busy(bz_1),
      .done(dn_1), .done_id(di_1), .rx_data(rx_1)
   );

   shiftreg_sequencer #(.DIV(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(v0_3), .req0_data(d0_3), .req0_ready(r0_3),
      .req1_valid(v1_3), .req1_data(d1_3), .req1_ready(r1_3),
      .sin(sin3), .sout(so_3), .sout_valid(sv_3), .busy(bz_3),
      .done(dn_3), .done_id(di_3), .rx_data(rx_3)
   );

   // external loop: DIV=3 instance receives its own serial output
   assign sin3 = so_3;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // ---------------- behavioural model ----------------
   // A frame is described by the number of edges k since its transfer edge:
   // k in 1..8*DIV carries data bit (k-1)/DIV, then the parity bit (if any),
   // then one done cycle.
   bit         m_in  [2];
   int         m_k   [2];
   logic [7:0] m_byte[2];
   logic [7:0] m_rxs [2];
   logic [7:0] m_rxh [2];
   bit         m_id  [2];
   bit         m_ptr [2];

   task automatic model_cycle(input int u, input int dv,
                              input logic v0, input logic v1,
                              input logic [7:0] d0, input logic [7:0] d1, input logic sn,
                              input logic a_r0, input logic a_r1, input logic a_so,
                              input logic a_sv, input logic a_bz, input logic a_dn,
                              input logic a_di, input logic [7:0] a_rx);
      logic e_r0, e_r1, e_so, e_sv, e_bz, e_dn, e_di;
      logic [7:0] e_rx;
      int k;
      string p;
      p = $sformatf("div%0d ", dv);
      e_r0 = 0; e_r1 = 0; e_so = 0; e_sv = 0; e_bz = 0; e_dn = 0; e_di = 0;
      if (!rst_n) begin
         m_in[u] = 0; m_k[u] = 0; m_ptr[u] = 0; m_id[u] = 0;
         m_rxs[u] = 8'h00; m_rxh[u] = 8'h00;
      end
      e_rx = m_rxh[u];
      if (rst_n && !m_in[u]) begin
         e_r0 = v0 && (!v1 || m_ptr[u] == 1'b0);
         e_r1 = v1 && (!v0 || m_ptr[u] == 1'b1);
      end else if (rst_n) begin
         k    = m_k[u];
         e_bz = 1;
         if (k <= 8*dv) begin
            e_sv = 1;
            e_so = m_byte[u][7 - (k-1)/dv];
         end else if (k <= NB*dv) begin
            e_sv = 1;
            e_so = ^m_byte[u];
         end else begin
            e_dn = 1;
            e_di = m_id[u];
            e_rx = m_rxs[u];
         end
      end
      chk({p, "req0_ready"}, 32'(a_r0), 32'(e_r0));
      chk({p, "req1_ready"}, 32'(a_r1), 32'(e_r1));
      chk({p, "sout"},       32'(a_so), 32'(e_so));
      chk({p, "sout_valid"}, 32'(a_sv), 32'(e_sv));
      chk({p, "busy"},       32'(a_bz), 32'(e_bz));
      chk({p, "done"},       32'(a_dn), 32'(e_dn));
      chk({p, "rx_data"},    32'(a_rx), 32'(e_rx));
      if (e_dn || !rst_n) chk({p, "done_id"}, 32'(a_di), 32'(e_di));
      // advance to the state after the coming rising edge
      if (rst_n) begin
         if (!m_in[u]) begin
            if ((e_r0 && v0) || (e_r1 && v1)) begin
               m_in[u]   = 1;
               m_k[u]    = 1;
               m_byte[u] = e_r1 ? d1 : d0;
               m_id[u]   = e_r1;
               m_ptr[u]  = ~m_ptr[u];
            end
         end else if (m_k[u] == NB*dv + 1) begin
            m_in[u]  = 0;
            m_rxh[u] = m_rxs[u];
         end else begin
            if (m_k[u] <= 8*dv && (m_k[u] % dv) == 0) m_rxs[u] = {m_rxs[u][6:0], sn};
            m_k[u]++;
         end
      end
   endtask

   always @(negedge clk) begin
      model_cycle(0, 1, v0_1, v1_1, d0_1, d1_1, sin1,
                  r0_1, r1_1, so_1, sv_1, bz_1, dn_1, di_1, rx_1);
      model_cycle(1, 3, v0_3, v1_3, d0_3, d1_3, sin3,
                  r0_3, r1_3, so_3, sv_3, bz_3, dn_3, di_3, rx_3);
   end

   // ---------------- event recorder for directed checks ----------------
   int         cyc = 0;
   bit         q_so1[$], q_so3[$], q_xid1[$], q_di1[$];
   int         q_x1[$], q_d1[$], q_x3[$], q_d3[$];
   logic [7:0] q_rx1[$], q_rx3[$];
   int         viol = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if ((r0_1 && v0_1) || (r1_1 && v1_1)) begin
         q_x1.push_back(cyc);
         q_xid1.push_back(r1_1 && v1_1);
      end
      if (sv_1) q_so1.push_back(so_1);
      if (dn_1) begin q_d1.push_back(cyc); q_di1.push_back(di_1); q_rx1.push_back(rx_1); end
      if (bz_1 && (r0_1 || r1_1)) viol++;
      if (r0_3 && v0_3) q_x3.push_back(cyc);
      if (sv_3) q_so3.push_back(so_3);
      if (dn_3) begin q_d3.push_back(cyc); q_rx3.push_back(rx_3); end
   end

   initial begin
      sin1 = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (sin_tog) sin1 = ~sin1;
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic clear_q();
      q_so1.delete(); q_so3.delete(); q_xid1.delete(); q_di1.delete();
      q_x1.delete(); q_d1.delete(); q_x3.delete(); q_d3.delete();
      q_rx1.delete(); q_rx3.delete();
   endtask

   task automatic wait_d1(input int n, input int bound, input string nm);
      for (int i = 0; i < bound && q_d1.size() < n; i++) step();
      chk(nm, 32'(q_d1.size() >= n), 32'd1);
   endtask

   task automatic wait_d3(input int n, input int bound, input string nm);
      for (int i = 0; i < bound && q_d3.size() < n; i++) step();
      chk(nm, 32'(q_d3.size() >= n), 32'd1);
   endtask

   // keep offers up until accepted; drop_both withdraws every offer after the first acceptance
   task automatic hold_offers(input int bound, input bit drop_both);
      logic g0, g1;
      for (int i = 0; i < bound; i++) begin
         if (!v0_1 && !v1_1) break;
         @(negedge clk);
         g0 = r0_1 && v0_1;
         g1 = r1_1 && v1_1;
         @(posedge clk); #1;
         if (g0 || (drop_both && g1)) v0_1 = 1'b0;
         if (g1 || (drop_both && g0)) v1_1 = 1'b0;
      end
      chk("offers accepted", 32'({v0_1, v1_1}), 32'd0);
   endtask

   function automatic logic [7:0] so1_byte(input int start);
      logic [7:0] b = 8'h00;
      for (int i = 0; i < 8; i++) b = {b[6:0], q_so1[start + i]};
      return b;
   endfunction

   initial begin
      logic [7:0] b3;
      int         nd;
      bit         ok;
      rst_n = 1'b0;
      v0_1 = 0; v1_1 = 0; v0_3 = 0; v1_3 = 0;
      d0_1 = 0; d1_1 = 0; d0_3 = 0; d1_3 = 0;
      sin_tog = 0;

      // reset state
      step();
      chk("reset outs div1", 32'({r0_1, r1_1, so_1, sv_1, bz_1, dn_1, di_1, rx_1}), 32'd0);
      chk("reset outs div3", 32'({r0_3, r1_3, so_3, sv_3, bz_3, dn_3, di_3, rx_3}), 32'd0);
      step(); step();
      rst_n = 1'b1;
      step();

      // single requester, 0xA5, sin held high
      clear_q();
      v0_1 = 1; d0_1 = 8'hA5;
      step();
      v0_1 = 0;
      wait_d1(1, 40, "A5 done seen");
      step(); step();
      chk("A5 ready pulses", 32'(q_x1.size()), 32'd1);
      chk("A5 sout bits", 32'(so1_byte(0)), 32'hA5);
      chk("A5 bit count", 32'(q_so1.size()), 32'(NB));
      chk("A5 latency", 32'(q_d1[0] - q_x1[0]), (NB == 8) ? 32'd9 : 32'd10);
      chk("A5 done_id", 32'(q_di1[0]), 32'd0);
      chk("A5 rx_data", 32'(q_rx1[0]), 32'hFF);
`ifdef SHIFTREG_SEQ_PARITY_EN
      chk("A5 parity bit", 32'(q_so1[8]), 32'd0);
      clear_q();
      v0_1 = 1; d0_1 = 8'h07;
      step();
      v0_1 = 0;
      wait_d1(1, 40, "07 done seen");
      chk("07 parity bit", 32'(q_so1[8]), 32'd1);
      chk("07 latency", 32'(q_d1[0] - q_x1[0]), 32'd10);
`endif

      // both requesters valid from reset
      rst_n = 1'b0; step(); rst_n = 1'b1; step();
      clear_q();
      sin_tog = 1;
      v0_1 = 1; d0_1 = 8'h0F; v1_1 = 1; d1_1 = 8'hF0;
      hold_offers(60, 1'b0);
      wait_d1(2, 40, "rr two dones");
      chk("rr first id", 32'(q_di1[0]), 32'd0);
      chk("rr second id", 32'(q_di1[1]), 32'd1);
      chk("rr first byte", 32'(so1_byte(0)), 32'h0F);
      chk("rr second byte", 32'(so1_byte(NB)), 32'hF0);

      // req1 arrives mid-frame and is served right after
      step();
      clear_q();
      viol = 0;
      v0_1 = 1; d0_1 = 8'h5A;
      step();
      v0_1 = 0;
      step(); step(); step();
      v1_1 = 1; d1_1 = 8'hC3;
      hold_offers(40, 1'b0);
      wait_d1(2, 40, "mid two dones");
      chk("mid ready while busy", 32'(viol), 32'd0);
      chk("mid second xfer id", 32'(q_xid1[1]), 32'd1);
      chk("mid served at idle", 32'(q_x1[1] - q_d1[0]), 32'd1);
      chk("mid done_id", 32'(q_di1[1]), 32'd1);

      // DIV=3 loopback with 0x3C
      clear_q();
      v0_3 = 1; d0_3 = 8'h3C;
      step();
      v0_3 = 0;
      wait_d3(1, 100, "div3 done seen");
      chk("div3 rx_data", 32'(q_rx3[0]), 32'h3C);
      chk("div3 latency", 32'(q_d3[0] - q_x3[0]), (NB == 8) ? 32'd25 : 32'd28);
      chk("div3 sout samples", 32'(q_so3.size()), 32'(NB * 3));
      b3 = 8'h3C;
      ok = 1;
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 3; j++)
            if (q_so3[i*3 + j] != b3[7 - i]) ok = 0;
      chk("div3 bit hold", 32'(ok), 32'd1);

      // reset during bit 4, then a clean frame
      step();
      clear_q();
      v0_1 = 1; d0_1 = 8'hC3;
      step();
      v0_1 = 0;
      for (int i = 0; i < 20 && q_so1.size() < 4; i++) step();
      chk("abort reached bit4", 32'(q_so1.size()), 32'd4);
      nd = q_d1.size();
      #1 rst_n = 1'b0;
      #1 chk("abort outs zero", 32'({r0_1, r1_1, so_1, sv_1, bz_1, dn_1, di_1, rx_1}), 32'd0);
      step();
      rst_n = 1'b1;
      repeat (15) step();
      chk("abort no done", 32'(q_d1.size()), 32'(nd));
      clear_q();
      v0_1 = 1; d0_1 = 8'h81; v1_1 = 1; d1_1 = 8'h7E;
      hold_offers(10, 1'b1);
      wait_d1(1, 40, "clean done seen");
      step(); step();
      chk("clean winner", 32'(q_xid1[0]), 32'd0);
      chk("clean one xfer", 32'(q_x1.size()), 32'd1);
      chk("clean sout bits", 32'(so1_byte(0)), 32'h81);
      chk("clean latency", 32'(q_d1[0] - q_x1[0]), (NB == 8) ? 32'd9 : 32'd10);

      repeat (3) step();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
